// File: rtl/lab5_pkg.sv
// Shared types and seven-segment constants for the lab 5 counter family.
package lab5_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  // Active-low segments, gfedcba bit order.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // A divide-by-1 prescaler still gets one bit so the register is never zero-width.
  function automatic int presc_width(int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/lab5_countdown_timer_if.sv
// Load/enable inputs and count/display outputs of the countdown timer.
interface lab5_countdown_timer_if;
  logic        load;
  logic [15:0] load_value;
  logic        enable;
  logic [15:0] Q;
  logic        zero;
  logic        done;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;

  modport master (
    output load, load_value, enable,
    input  Q, zero, done, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  load, load_value, enable,
    output Q, zero, done, HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/lab5_countdown_timer_hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_7seg
  import lab5_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/lab5_countdown_timer.sv
// Loadable 16-bit countdown timer with prescaled tick, expiry pulse and hex display.
// Optional periodic mode: define COUNTDOWN_AUTORELOAD_EN to reload on expiry.
module lab5_countdown_timer
  import lab5_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input logic                    clock,
  input logic                    reset,
  lab5_countdown_timer_if.slave  bus
);

  localparam int            PW         = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [15:0]   reload_q, reload_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      state_d  = IDLE;
      count_d  = bus.load_value;
      presc_d  = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_d = bus.load_value;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable && count_q != '0) begin
            state_d = COUNT;
            presc_d = '0;
          end
        end
        COUNT: begin
          if (bus.enable) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              if (count_q == 16'd1) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = EXPIRED;
`endif
              end else if (count_q != '0) begin
                count_d = count_q - 16'd1;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.Q    = count_q;
  assign bus.zero = (count_q == '0);
  assign bus.done = done_q;

  hex_to_7seg u_hex0 (.nibble_i(count_q[3:0]),   .seg_o(bus.HEX0));
  hex_to_7seg u_hex1 (.nibble_i(count_q[7:4]),   .seg_o(bus.HEX1));
  hex_to_7seg u_hex2 (.nibble_i(count_q[11:8]),  .seg_o(bus.HEX2));
  hex_to_7seg u_hex3 (.nibble_i(count_q[15:12]), .seg_o(bus.HEX3));

endmodule

// File: tb/tb_lab5_countdown_timer.sv
// Scoreboard bench: two timers (divide-by-1 and divide-by-4) share one stimulus stream.
module tb_lab5_countdown_timer;
  import lab5_pkg::*;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  lab5_countdown_timer_if if1 ();
  lab5_countdown_timer_if if4 ();

  lab5_countdown_timer #(.TICK_DIV(1)) dut1 (.clock(clk), .reset(rst), .bus(if1));
  lab5_countdown_timer #(.TICK_DIV(4)) dut4 (.clock(clk), .reset(rst), .bus(if4));

  typedef struct {
    int q;
    int reload;
    int phase;
    bit running;
    bit expired;
    bit done;
  } mdl_t;

  typedef struct {
    int     q1;
    int     q4;
    bit     d1;
    bit     d4;
    state_e s1;
    state_e s4;
  } exp_t;

  exp_t exp_fifo[$];
  mdl_t m1, m4;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behaviour per the timer rules: phase counts enabled edges since the last tick.
  function automatic mdl_t step(mdl_t m, int div, bit r, bit ld, int lv, bit en);
    mdl_t n = m;
    n.done = 1'b0;
    if (r) begin
      n = '{default: 0};
    end else if (ld) begin
      n.q = lv; n.reload = lv; n.phase = 0; n.running = 0; n.expired = 0;
    end else if (n.expired) begin
    end else if (!n.running) begin
      if (en && n.q != 0) begin
        n.running = 1; n.phase = 0;
      end
    end else if (en) begin
      n.phase = n.phase + 1;
      if (n.phase == div) begin
        n.phase = 0;
        if (n.q == 1) begin
          n.done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          n.q = n.reload;
`else
          n.q = 0; n.running = 0; n.expired = 1;
`endif
        end else begin
          n.q = n.q - 1;
        end
      end
    end
    return n;
  endfunction

  function automatic state_e mstate(mdl_t m);
    return m.expired ? EXPIRED : (m.running ? COUNT : IDLE);
  endfunction

  task automatic check(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  task automatic cycle(bit r, bit ld, int lv, bit en);
    exp_t e;
    @(negedge clk);
    rst = r;
    if1.load = ld; if1.load_value = lv[15:0]; if1.enable = en;
    if4.load = ld; if4.load_value = lv[15:0]; if4.enable = en;
    m1 = step(m1, 1, r, ld, lv, en);
    m4 = step(m4, 4, r, ld, lv, en);
    e.q1 = m1.q; e.d1 = m1.done; e.s1 = mstate(m1);
    e.q4 = m4.q; e.d4 = m4.done; e.s4 = mstate(m4);
    exp_fifo.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_fifo.size() > 0) begin
        e = exp_fifo.pop_front();
        check("q_div1",    int'(if1.Q), e.q1);
        check("zero_div1", int'(if1.zero), int'(e.q1 == 0));
        check("done_div1", int'(if1.done), int'(e.d1));
        check("state_div1", int'(dut1.state_q), int'(e.s1));
        check("hex0_div1", int'(if1.HEX0), int'(seg_ref[e.q1 & 15]));
        check("hex1_div1", int'(if1.HEX1), int'(seg_ref[(e.q1 >> 4) & 15]));
        check("hex2_div1", int'(if1.HEX2), int'(seg_ref[(e.q1 >> 8) & 15]));
        check("hex3_div1", int'(if1.HEX3), int'(seg_ref[(e.q1 >> 12) & 15]));
        check("q_div4",    int'(if4.Q), e.q4);
        check("zero_div4", int'(if4.zero), int'(e.q4 == 0));
        check("done_div4", int'(if4.done), int'(e.d4));
        check("state_div4", int'(dut4.state_q), int'(e.s4));
        check("hex0_div4", int'(if4.HEX0), int'(seg_ref[e.q4 & 15]));
        check("hex3_div4", int'(if4.HEX3), int'(seg_ref[(e.q4 >> 12) & 15]));
      end
    end
  end

  initial begin : driver
    int r, ld, lv, en;
    rst = 1'b1;
    if1.load = 0; if1.load_value = '0; if1.enable = 0;
    if4.load = 0; if4.load_value = '0; if4.enable = 0;
    m1 = '{default: 0};
    m4 = '{default: 0};

    repeat (2) cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);

    cycle(0, 1, 16'h0005, 1);
    repeat (20) cycle(0, 0, 0, 1);

    cycle(0, 1, 16'h0003, 1);
    repeat (5) cycle(0, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 1);

    cycle(0, 1, 16'h00A7, 0);
    repeat (4) cycle(0, 0, 0, 1);
    cycle(0, 1, 16'h1234, 1);
    repeat (2) cycle(0, 0, 0, 0);

    cycle(0, 1, 16'h0000, 1);
    repeat (8) cycle(0, 0, 0, 1);

    cycle(0, 1, 16'h0003, 1);
    repeat (6) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 23) == 0);
      lv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                       : int'($urandom_range(0, 9));
      en = ($urandom_range(0, 4) != 0);
      cycle(r[0], ld[0], lv, en[0]);
    end

    for (int i = 0; i < 5 && exp_fifo.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_fifo.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_fifo.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
